// File: rtl/edge_detector_pkg.sv
// Shared types for the multi-channel edge detector: edge qualification modes
// and the helper that decides whether a filtered edge sets a pending flag.
package edge_detector_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2,
      EDGE_BOTH = 2'd3
   } edge_mode_e;

   function automatic logic edge_qualifies(input edge_mode_e mode,
                                           input logic       rise,
                                           input logic       fall);
      logic q;
      case (mode)
         EDGE_OFF:  q = 1'b0;
         EDGE_RISE: q = rise;
         EDGE_FALL: q = fall;
         EDGE_BOTH: q = rise | fall;
         default:   q = 1'b0;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One channel: synchroniser chain, stability filter and registered edge pulses.
// rise_nxt_o/fall_nxt_o flag the edge one cycle early so pending logic lines up with the pulse.
module edge_filter_ch #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 4
) (
   input  logic              clk_i,
   input  logic              arst_ni,
   input  logic              sig_i,
   input  logic [FILT_W-1:0] filt_len_i,
   output logic              level_o,
   output logic              rise_o,
   output logic              fall_o,
   output logic              rise_nxt_o,
   output logic              fall_nxt_o
);

   logic              s_s;
   logic              lvl_r;
   logic              lvl_nxt_s;
   logic [FILT_W-1:0] cnt_r;
   logic [FILT_W-1:0] cnt_nxt_s;
   logic              commit_s;
   logic              rise_r;
   logic              fall_r;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_s = sig_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_r;

         // Synchroniser shift chain
         always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
               sync_r <= {SYNC_STAGES{1'b0}};
            end else begin
               sync_r[0] <= sig_i;
               for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                  sync_r[i] <= sync_r[i-1];
               end
            end
         end

         assign s_s = sync_r[SYNC_STAGES-1];
      end
   endgenerate

   // Filter next state: commit only after filt_len_i+1 consecutive mismatches
   always_comb begin
      lvl_nxt_s = lvl_r;
      cnt_nxt_s = cnt_r;
      commit_s  = 1'b0;
      if (s_s == lvl_r) begin
         cnt_nxt_s = {FILT_W{1'b0}};
      end else if (cnt_r >= filt_len_i) begin
         commit_s  = 1'b1;
         lvl_nxt_s = s_s;
         cnt_nxt_s = {FILT_W{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + FILT_W'(1);
      end
   end

   assign rise_nxt_o = commit_s & s_s;
   assign fall_nxt_o = commit_s & ~s_s;

   // Filter state and pulse registers
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         lvl_r  <= 1'b0;
         cnt_r  <= {FILT_W{1'b0}};
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         lvl_r  <= lvl_nxt_s;
         cnt_r  <= cnt_nxt_s;
         rise_r <= rise_nxt_o;
         fall_r <= fall_nxt_o;
      end
   end

   assign level_o = lvl_r;
   assign rise_o  = rise_r;
   assign fall_o  = fall_r;

endmodule

// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: per-channel filters, sticky pending flags and irq.
// Optional saturating edge counters are built when EDGE_DET_COUNT_EN is defined.
module edge_detector_mc
   import edge_detector_pkg::*;
#(
   parameter int unsigned NUM_CH      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                    clk_i,
   input  logic                    arst_ni,
   input  logic [NUM_CH-1:0]       signal_i,
   input  logic [FILT_W-1:0]       filt_len_i,
   input  logic [2*NUM_CH-1:0]     mode_i,
   input  logic [NUM_CH-1:0]       clear_i,
   output logic [NUM_CH-1:0]       level_o,
   output logic [NUM_CH-1:0]       rising_edge_o,
   output logic [NUM_CH-1:0]       falling_edge_o,
   output logic [NUM_CH-1:0]       pending_o,
   output logic                    irq_o,
   output logic [NUM_CH*CNT_W-1:0] count_o
);

   logic [NUM_CH-1:0] rise_nxt_s;
   logic [NUM_CH-1:0] fall_nxt_s;
   logic [NUM_CH-1:0] qual_s;
   logic [NUM_CH-1:0] pending_r;

   for (genvar n = 0; n < int'(NUM_CH); n++) begin : g_ch
      edge_filter_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_W      (FILT_W)
      ) u_filt (
         .clk_i      (clk_i),
         .arst_ni    (arst_ni),
         .sig_i      (signal_i[n]),
         .filt_len_i (filt_len_i),
         .level_o    (level_o[n]),
         .rise_o     (rising_edge_o[n]),
         .fall_o     (falling_edge_o[n]),
         .rise_nxt_o (rise_nxt_s[n]),
         .fall_nxt_o (fall_nxt_s[n])
      );
   end

   // Edge qualification against each channel's mode
   always_comb begin
      qual_s = {NUM_CH{1'b0}};
      for (int n = 0; n < int'(NUM_CH); n++) begin
         qual_s[n] = edge_qualifies(edge_mode_e'(mode_i[2*n +: 2]), rise_nxt_s[n], fall_nxt_s[n]);
      end
   end

   // Sticky pending flags; a new event beats a simultaneous clear
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         pending_r <= {NUM_CH{1'b0}};
      end else begin
         pending_r <= qual_s | (pending_r & ~clear_i);
      end
   end

   assign pending_o = pending_r;
   assign irq_o     = |pending_r;

`ifdef EDGE_DET_COUNT_EN
   logic [NUM_CH*CNT_W-1:0] count_r;

   // Saturating per-channel event counters
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         count_r <= {(NUM_CH*CNT_W){1'b0}};
      end else begin
         for (int n = 0; n < int'(NUM_CH); n++) begin
            if (clear_i[n]) begin
               count_r[n*CNT_W +: CNT_W] <= qual_s[n] ? CNT_W'(1) : {CNT_W{1'b0}};
            end else if (qual_s[n] && (count_r[n*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
               count_r[n*CNT_W +: CNT_W] <= count_r[n*CNT_W +: CNT_W] + CNT_W'(1);
            end else begin
               count_r[n*CNT_W +: CNT_W] <= count_r[n*CNT_W +: CNT_W];
            end
         end
      end
   end

   assign count_o = count_r;
`else
   assign count_o = {(NUM_CH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_edge_detector_mc.sv
// Self-checking bench for edge_detector_mc (4 channels); the reference model judges
// each filter from a history of synchronised samples rather than a running counter.
module tb_edge_detector_mc;

   localparam int NUM_CH = 4;
   localparam int SYNC   = 2;
   localparam int FILT_W = 4;
   localparam int CNT_W  = 8;

   logic        clk_i = 1'b0;
   logic        arst_ni;
   logic [3:0]  signal_i;
   logic [3:0]  filt_len_i;
   logic [7:0]  mode_i;
   logic [3:0]  clear_i;
   logic [3:0]  level_o;
   logic [3:0]  rising_edge_o;
   logic [3:0]  falling_edge_o;
   logic [3:0]  pending_o;
   logic        irq_o;
   logic [31:0] count_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   edge_detector_mc #(
      .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .signal_i(signal_i), .filt_len_i(filt_len_i),
      .mode_i(mode_i), .clear_i(clear_i), .level_o(level_o), .rising_edge_o(rising_edge_o),
      .falling_edge_o(falling_edge_o), .pending_o(pending_o), .irq_o(irq_o), .count_o(count_o)
   );

   // Reference model state
   logic [3:0]  m_pipe [SYNC];
   logic [31:0] m_hist [NUM_CH];
   logic [7:0]  m_cnt  [NUM_CH];
   logic [3:0]  m_lvl, m_rise, m_fall, m_pend;
   logic [31:0] n_hist [NUM_CH];
   logic [7:0]  n_cnt  [NUM_CH];
   logic [3:0]  n_lvl, n_rise, n_fall, n_pend, s_cur;
   int          m_run;
   logic        m_stop;
   logic [1:0]  m_md;
   logic        m_q;

   // Level flips once the newest filt_len+1 samples all disagree with it
   always_comb begin
      n_lvl  = m_lvl;
      n_rise = 4'h0;
      n_fall = 4'h0;
      n_pend = m_pend;
      n_hist = m_hist;
      n_cnt  = m_cnt;
      s_cur  = m_pipe[SYNC-1];
      m_run  = 0;
      m_stop = 1'b0;
      m_md   = 2'd0;
      m_q    = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         n_hist[ch] = {m_hist[ch][30:0], s_cur[ch]};
         m_run  = 0;
         m_stop = 1'b0;
         for (int i = 0; i < 32; i++) begin
            if (!m_stop) begin
               if (n_hist[ch][i] != m_lvl[ch]) m_run = m_run + 1;
               else m_stop = 1'b1;
            end
         end
         if (m_run >= int'(filt_len_i) + 1) begin
            n_lvl[ch]  = s_cur[ch];
            n_rise[ch] = s_cur[ch];
            n_fall[ch] = ~s_cur[ch];
         end
         m_md = mode_i[2*ch +: 2];
         m_q  = (n_rise[ch] && (m_md == 2'd1 || m_md == 2'd3)) ||
                (n_fall[ch] && (m_md == 2'd2 || m_md == 2'd3));
         if (m_q) n_pend[ch] = 1'b1;
         else if (clear_i[ch]) n_pend[ch] = 1'b0;
         if (clear_i[ch]) n_cnt[ch] = m_q ? 8'd1 : 8'd0;
         else if (m_q && m_cnt[ch] != 8'd255) n_cnt[ch] = m_cnt[ch] + 8'd1;
      end
   end

   always @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int i = 0; i < SYNC; i++) m_pipe[i] <= 4'h0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_hist[c] <= 32'd0;
            m_cnt[c]  <= 8'd0;
         end
         m_lvl  <= 4'h0;
         m_rise <= 4'h0;
         m_fall <= 4'h0;
         m_pend <= 4'h0;
      end else begin
         m_pipe[0] <= signal_i;
         for (int i = 1; i < SYNC; i++) m_pipe[i] <= m_pipe[i-1];
         m_hist <= n_hist;
         m_cnt  <= n_cnt;
         m_lvl  <= n_lvl;
         m_rise <= n_rise;
         m_fall <= n_fall;
         m_pend <= n_pend;
      end
   end

   logic [31:0] exp_cnt;
`ifdef EDGE_DET_COUNT_EN
   assign exp_cnt = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
`else
   assign exp_cnt = 32'd0;
`endif

   logic [48:0] obs_w, exp_w;
   assign obs_w = {level_o, rising_edge_o, falling_edge_o, pending_o, irq_o, count_o};
   assign exp_w = {m_lvl, m_rise, m_fall, m_pend, |m_pend, exp_cnt};

   task automatic test_reset();
      arst_ni = 1'b0; signal_i = 4'hF; filt_len_i = 4'd0; mode_i = 8'h00; clear_i = 4'h0;
      repeat (3) @(negedge clk_i);
      checks++;
      if (obs_w !== 49'd0) begin errors++; $display("FAIL reset_outputs obs=%h exp=0", obs_w); end
      arst_ni = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_i);
         checks++;
         if (rising_edge_o !== ((k == 3) ? 4'hF : 4'h0)) begin
            errors++; $display("FAIL reset_rise edge=%0d obs=%h", k, rising_edge_o);
         end
         checks++;
         if (obs_w !== exp_w) begin errors++; $display("FAIL reset_model obs=%h exp=%h", obs_w, exp_w); end
      end
      checks++;
      if (level_o !== 4'hF) begin errors++; $display("FAIL reset_level obs=%h exp=f", level_o); end
   endtask

   task automatic test_filter();
      signal_i = 4'h0;
      repeat (6) @(negedge clk_i);
      filt_len_i = 4'd3;
      signal_i[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk_i);
         checks++;
         if (level_o[0] !== 1'b0 || rising_edge_o[0] !== 1'b0) begin
            errors++; $display("FAIL filt_short k=%0d lvl=%b rise=%b exp=0", k, level_o[0], rising_edge_o[0]);
         end
         checks++;
         if (obs_w !== exp_w) begin errors++; $display("FAIL filt_model obs=%h exp=%h", obs_w, exp_w); end
         if (k == 3) signal_i[0] = 1'b0;
      end
      signal_i[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_i);
         checks++;
         if (rising_edge_o[0] !== (k == 6) || level_o[0] !== (k == 6)) begin
            errors++; $display("FAIL filt_long k=%0d lvl=%b rise=%b", k, level_o[0], rising_edge_o[0]);
         end
         checks++;
         if (obs_w !== exp_w) begin errors++; $display("FAIL filt_model obs=%h exp=%h", obs_w, exp_w); end
      end
      signal_i[0] = 1'b0;
      repeat (8) @(negedge clk_i);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL filt_return obs=%h exp=%h", obs_w, exp_w); end
   endtask

   task automatic test_fall_mode();
      int saw_r = 0;
      int saw_f = 0;
      filt_len_i = 4'd0;
      mode_i = 8'b00_00_10_00;
      signal_i[1] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_i);
         checks++;
         if (obs_w !== exp_w) begin errors++; $display("FAIL fall_model obs=%h exp=%h", obs_w, exp_w); end
         if (rising_edge_o[1]) begin
            saw_r++;
            checks++;
            if (pending_o[1] !== 1'b0) begin errors++; $display("FAIL fall_pend_on_rise obs=%b exp=0", pending_o[1]); end
         end
         if (falling_edge_o[1]) begin
            saw_f++;
            checks++;
            if (pending_o[1] !== 1'b1 || irq_o !== 1'b1) begin
               errors++; $display("FAIL fall_pend obs=%b irq=%b exp=1", pending_o[1], irq_o);
            end
         end
         if (k == 3) signal_i[1] = 1'b0;
      end
      checks++;
      if (saw_r != 1 || saw_f != 1) begin errors++; $display("FAIL fall_pulses rises=%0d falls=%0d exp=1,1", saw_r, saw_f); end
      clear_i[1] = 1'b1;
      @(negedge clk_i);
      clear_i[1] = 1'b0;
      checks++;
      if (pending_o !== 4'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL fall_clear pend=%h irq=%b exp=0", pending_o, irq_o); end
   endtask

   task automatic test_set_wins();
      mode_i = 8'b00_11_00_00;
      signal_i[2] = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      clear_i[2] = 1'b1;
      @(negedge clk_i);
      checks++;
      if (pending_o[2] !== 1'b1 || rising_edge_o[2] !== 1'b1) begin
         errors++; $display("FAIL setwins pend=%b rise=%b exp=1,1", pending_o[2], rising_edge_o[2]);
      end
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL setwins_model obs=%h exp=%h", obs_w, exp_w); end
      @(negedge clk_i);
      clear_i[2] = 1'b0;
      checks++;
      if (pending_o[2] !== 1'b0 || irq_o !== 1'b0) begin
         errors++; $display("FAIL setwins_clear pend=%b irq=%b exp=0", pending_o[2], irq_o);
      end
      mode_i = 8'h00;
   endtask

   task automatic test_counter();
      mode_i = 8'b11_00_00_00;
      clear_i[3] = 1'b1;
      @(negedge clk_i);
      clear_i[3] = 1'b0;
      for (int k = 0; k < 300; k++) begin
         signal_i[3] = ~signal_i[3];
         @(negedge clk_i);
         checks++;
         if (obs_w !== exp_w) begin errors++; $display("FAIL cnt_model k=%0d obs=%h exp=%h", k, obs_w, exp_w); end
      end
      repeat (3) @(negedge clk_i);
`ifdef EDGE_DET_COUNT_EN
      checks++;
      if (count_o[31:24] !== 8'd255) begin errors++; $display("FAIL cnt_sat obs=%0d exp=255", count_o[31:24]); end
`else
      checks++;
      if (count_o !== 32'd0) begin errors++; $display("FAIL cnt_absent obs=%h exp=0", count_o); end
`endif
      for (int k = 0; k < 3; k++) begin
         signal_i[3] = ~signal_i[3];
         @(negedge clk_i);
      end
      signal_i[3] = ~signal_i[3];
      clear_i[3] = 1'b1;
      @(negedge clk_i);
      clear_i[3] = 1'b0;
`ifdef EDGE_DET_COUNT_EN
      checks++;
      if (count_o[31:24] !== 8'd1) begin errors++; $display("FAIL cnt_clear_edge obs=%0d exp=1", count_o[31:24]); end
`else
      checks++;
      if (count_o !== 32'd0) begin errors++; $display("FAIL cnt_clear_absent obs=%h exp=0", count_o); end
`endif
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL cnt_clear_model obs=%h exp=%h", obs_w, exp_w); end
      mode_i = 8'h00;
      clear_i = 4'hF;
      repeat (4) @(negedge clk_i);
      clear_i = 4'h0;
   endtask

   task automatic test_filt_lower();
      filt_len_i = 4'd15;
      signal_i[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         checks++;
         if (level_o[0] !== 1'b0) begin errors++; $display("FAIL lower_hold k=%0d obs=%b exp=0", k, level_o[0]); end
      end
      filt_len_i = 4'd2;
      @(negedge clk_i);
      checks++;
      if (level_o[0] !== 1'b1 || rising_edge_o[0] !== 1'b1) begin
         errors++; $display("FAIL lower_commit lvl=%b rise=%b exp=1,1", level_o[0], rising_edge_o[0]);
      end
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL lower_model obs=%h exp=%h", obs_w, exp_w); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         for (int b = 0; b < NUM_CH; b++) begin
            if ($urandom_range(0, 3) == 0) signal_i[b] = ~signal_i[b];
            clear_i[b] = ($urandom_range(0, 7) == 0);
         end
         if (k % 50 == 0) filt_len_i = 4'($urandom_range(0, 4));
         if (k % 40 == 0) mode_i = 8'($urandom);
         if (k == 300) arst_ni = 1'b0;
         if (k == 302) arst_ni = 1'b1;
         @(negedge clk_i);
         checks++;
         if (obs_w !== exp_w) begin errors++; $display("FAIL rand_model k=%0d obs=%h exp=%h", k, obs_w, exp_w); end
         if (k == 301) begin
            checks++;
            if (obs_w !== 49'd0) begin errors++; $display("FAIL rand_reset obs=%h exp=0", obs_w); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_filter();
      test_fall_mode();
      test_set_wins();
      test_counter();
      test_filt_lower();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
